// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use/branch-operand stall and branch/jump flush sequencer
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_controller
`ifdef HAZARD_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_busy,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       if_id_uses_rt,
    input  logic       if_id_branch,
    input  logic       if_id_jump,
    input  logic       branch_taken,
    input  logic       id_ex_mem_read,
    input  logic       id_ex_reg_write,
    input  logic [4:0] id_ex_dst,
    input  logic       ex_mem_mem_read,
    input  logic [4:0] ex_mem_dst,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic       freeze
`ifdef HAZARD_STATS_EN
   ,output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t state_q, state_d;
    logic   rem_q, rem_d;
    logic   match_ex, match_mem, need1, need2, stall;

    always_comb begin
        match_ex  = (id_ex_dst != 5'd0) &&
                    ((id_ex_dst == if_id_rs) || (if_id_uses_rt && (id_ex_dst == if_id_rt)));
        match_mem = (ex_mem_dst != 5'd0) &&
                    ((ex_mem_dst == if_id_rs) || (if_id_uses_rt && (ex_mem_dst == if_id_rt)));
        // A branch compares in ID, so even an ALU result in EX is too late to forward.
        need2 = if_id_branch && id_ex_mem_read && match_ex;
        need1 = (id_ex_mem_read && match_ex) ||
                (if_id_branch && id_ex_reg_write && !id_ex_mem_read && match_ex) ||
                (if_id_branch && ex_mem_mem_read && match_mem);
        stall = (state_q == HOLD) || need1 || need2;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!mem_busy) begin
            if (state_q == HOLD) begin
                if (rem_q != 1'b0) rem_d = rem_q - 1'b1;
                if (rem_d == 1'b0) state_d = RUN;
            end else if (need2) begin
                state_d = HOLD;
                rem_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        freeze       = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            freeze      = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush = if_id_jump || (if_id_branch && branch_taken);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (id_ex_bubble && !mem_busy && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed vector bench for hazard_controller
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_busy;
    logic [4:0] if_id_rs, if_id_rt;
    logic       if_id_uses_rt, if_id_branch, if_id_jump, branch_taken;
    logic       id_ex_mem_read, id_ex_reg_write;
    logic [4:0] id_ex_dst;
    logic       ex_mem_mem_read;
    logic [4:0] ex_mem_dst;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] cnt_before;
`endif

    int checks = 0;
    int errors = 0;

    // Output vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_FLUSH = 5'b11010;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_BUSY  = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00100;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       jmp;
        logic       tk;
        logic       exmr;
        logic       exrw;
        logic [4:0] exdst;
        logic       memmr;
        logic [4:0] memdst;
        logic       busy;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[14];

    hazard_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_busy        (mem_busy),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_uses_rt   (if_id_uses_rt),
        .if_id_branch    (if_id_branch),
        .if_id_jump      (if_id_jump),
        .branch_taken    (branch_taken),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_dst       (id_ex_dst),
        .ex_mem_mem_read (ex_mem_mem_read),
        .ex_mem_dst      (ex_mem_dst),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .freeze          (freeze)
`ifdef HAZARD_STATS_EN
       ,.stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic apply(input vec_t v);
        if_id_rs        = v.rs;
        if_id_rt        = v.rt;
        if_id_uses_rt   = v.uses_rt;
        if_id_branch    = v.br;
        if_id_jump      = v.jmp;
        branch_taken    = v.tk;
        id_ex_mem_read  = v.exmr;
        id_ex_reg_write = v.exrw;
        id_ex_dst       = v.exdst;
        ex_mem_mem_read = v.memmr;
        ex_mem_dst      = v.memdst;
        mem_busy        = v.busy;
    endtask

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc/ifw/bub/flush/frz=%b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t idle, br_load, br_taken_clean;

    initial begin
        //            rs     rt     urt   br    jmp   tk    exmr  exrw  exdst  memmr memdst busy  exp
        idle    = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, O_RUN};
        vecs[0]  = idle;
        vecs[1]  = '{5'd8,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, O_STALL};
        vecs[2]  = '{5'd3,  5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, O_RUN};
        vecs[3]  = '{5'd3,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, O_STALL};
        vecs[4]  = '{5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, O_RUN};
        vecs[5]  = '{5'd2,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, O_STALL};
        vecs[6]  = '{5'd2,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, O_FLUSH};
        vecs[7]  = '{5'd7,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b0, O_STALL};
        vecs[8]  = '{5'd7,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd7,  1'b0, O_RUN};
        vecs[9]  = '{5'd4,  5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, O_FLUSH};
        vecs[10] = '{5'd4,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, O_RUN};
        vecs[11] = '{5'd8,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 5'd0,  1'b1, O_BUSY};
        vecs[12] = '{5'd9,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'd0,  1'b0, O_RUN};
        vecs[13] = '{5'd5,  5'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, O_BUSY};
        br_load        = '{5'd9, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, O_STALL};
        br_taken_clean = '{5'd9, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_FLUSH};

        rst_n = 1'b0;
        apply(idle);
        mem_busy = 1'b1;
        #1;
        chk("reset_outputs_busy", O_RST);
        mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", O_RST);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", stall_count);
        end
`endif
        rst_n = 1'b1;
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end
        apply(idle);
        tick();

        // Branch on a load in EX: two bubbles, HOLD ignores a MEM-stage load hazard, then flush.
        apply(br_load);
        #1;
        chk("brload_bubble1", O_STALL);
        tick();
        apply(br_load);
        id_ex_mem_read  = 1'b0;
        id_ex_reg_write = 1'b0;
        id_ex_dst       = 5'd0;
        ex_mem_mem_read = 1'b1;
        ex_mem_dst      = 5'd9;
        #1;
        chk("brload_bubble2", O_STALL);
        tick();
        apply(br_taken_clean);
        #1;
        chk("brload_resolve_flush", O_FLUSH);
        tick();
        apply(idle);
        tick();

        // mem_busy for 3 cycles in HOLD stretches the window but bubble count stays 2.
`ifdef HAZARD_STATS_EN
        cnt_before = stall_count;
`endif
        apply(br_load);
        #1;
        chk("busyhold_bubble1", O_STALL);
        tick();
        apply(br_taken_clean);
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("busyhold_freeze%0d", c), O_BUSY);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk("busyhold_bubble2", O_STALL);
        tick();
        chk("busyhold_resume_flush", O_FLUSH);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== cnt_before + 16'd2) begin
            errors++;
            $display("FAIL busyhold_count: got %0d expected %0d", stall_count, cnt_before + 16'd2);
        end
`endif
        tick();

        // Reset asserted mid-HOLD aborts the stall; resumes in RUN.
        apply(br_load);
        #1;
        chk("rsthold_bubble1", O_STALL);
        tick();
        apply(br_taken_clean);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rsthold_reset_outputs", O_RST);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rsthold_run_after_release", O_FLUSH);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rsthold_count: got %0d expected 0", stall_count);
        end
`endif
        tick();

`ifdef HAZARD_STATS_EN
        apply(vecs[1]);
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_saturate: got %0d expected 65535", stall_count);
        end
        apply(idle);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
